// File: rtl/my_pkg.sv
// Shared definitions for the platform interrupt controller: register offsets
// inside the 16 KiB window and the per-source trigger mode.
package my_pkg;

  localparam logic [13:0] IRQC_PRIO_OFS  = 14'h0000;
  localparam logic [13:0] IRQC_PEND_OFS  = 14'h1000;
  localparam logic [13:0] IRQC_EN_OFS    = 14'h2000;
  localparam logic [13:0] IRQC_MODE_OFS  = 14'h2004;
  localparam logic [13:0] IRQC_THR_OFS   = 14'h3000;
  localparam logic [13:0] IRQC_CLAIM_OFS = 14'h3004;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_t;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: input synchroniser, edge detect and the pending /
// in-service flops driven by the claim and complete strobes.
module irq_gateway
  import my_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      irq_line,
  input  irq_mode_t mode,
  input  logic      claim,
  input  logic      complete,
  output logic      pending
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;
  logic                   pending_r;
  logic                   in_service_r;
  logic                   s_s;
  logic                   rise_s;
  logic                   set_s;

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign rise_s = s_s & ~s_d_r;

  // Synchroniser chain plus the last-value flop used for rising-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      s_d_r  <= 1'b0;
    end else begin
      sync_r[0] <= irq_line;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      s_d_r <= s_s;
    end
  end

  // Edge sources latch every rise; level sources re-arm only once idle
  always_comb begin
    set_s = 1'b0;
    case (mode)
      IRQ_EDGE:  set_s = rise_s;
      IRQ_LEVEL: set_s = s_s & ~in_service_r & ~pending_r;
      default:   set_s = 1'b0;
    endcase
  end

  // A claim beats a same-cycle complete, and a same-cycle set beats a claim
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r    <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      pending_r    <= (pending_r & ~claim) | set_s;
      in_service_r <= claim | (in_service_r & ~complete);
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: memory-mapped register file, per-source
// gateways and priority arbitration onto the core's external interrupt line.
module irq_controller
  import my_pkg::*;
#(
  parameter int          NUM_SRC     = 31,
  parameter int          PRIO_W      = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               read,
  input  logic [31:0]        read_address,
  output logic [31:0]        DATA_out,
  input  logic [3:0]         write,
  input  logic [31:0]        write_address,
  input  logic [31:0]        DATA_in,
  output logic               irq_out,
  output logic [4:0]         claim_id
);

  localparam logic [31:0] SRC_MASK = ((32'h1 << NUM_SRC) - 32'h1) << 1;
  localparam logic [5:0]  NUM_SRC6 = 6'(NUM_SRC);

  logic [PRIO_W-1:0] prio_r [32];
  logic [31:0]       enable_r;
  logic [31:0]       mode_r;
  logic [PRIO_W-1:0] thr_r;

  logic [NUM_SRC:1]  pend_s;
  logic [NUM_SRC:1]  claim_s;
  logic [NUM_SRC:1]  complete_s;
  logic [31:0]       pend_vec_s;
  logic [4:0]        best_s;
  logic [PRIO_W-1:0] best_prio_s;
  logic              irq_cond_s;
  logic              rd_win_s;
  logic              wr_win_s;
  logic              wr_go_s;
  logic [13:0]       rd_ofs_s;
  logic [13:0]       wr_ofs_s;
  logic              claim_go_s;
  logic              complete_go_s;
  logic [31:0]       rd_data_s;

  // Word-aligned PRIORITY[1..NUM_SRC] slot; offset 0 is the reserved source
  function automatic logic prio_hit(input logic [13:0] ofs);
    return (ofs[13:7] == 7'h00) && (ofs[1:0] == 2'b00) &&
           (ofs[6:2] != 5'h00) && ({1'b0, ofs[6:2]} <= NUM_SRC6);
  endfunction

  assign rd_win_s = (read_address[31:14] == BASE_ADDR[31:14]);
  assign wr_win_s = (write_address[31:14] == BASE_ADDR[31:14]);
  assign rd_ofs_s = read_address[13:0];
  assign wr_ofs_s = write_address[13:0];
  assign wr_go_s  = wr_win_s && (write == 4'b1111);

  assign claim_go_s    = read && rd_win_s && (rd_ofs_s == IRQC_CLAIM_OFS) && irq_cond_s;
  assign complete_go_s = wr_go_s && (wr_ofs_s == IRQC_CLAIM_OFS) &&
                         (DATA_in != 32'h0) && (DATA_in <= 32'(NUM_SRC));

  for (genvar k = 1; k <= NUM_SRC; k++) begin : g_src
    irq_gateway #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_gw (
      .clk      (clk),
      .reset    (reset),
      .irq_line (irq_src[k-1]),
      .mode     (irq_mode_t'(mode_r[k])),
      .claim    (claim_s[k]),
      .complete (complete_s[k]),
      .pending  (pend_s[k])
    );
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties
  always_comb begin
    logic cand;
    cand        = 1'b0;
    best_s      = 5'h00;
    best_prio_s = {PRIO_W{1'b0}};
    pend_vec_s  = 32'h0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      pend_vec_s[k] = pend_s[k];
      cand          = pend_s[k] && enable_r[k] && (prio_r[k] > best_prio_s);
      best_s        = cand ? 5'(k) : best_s;
      best_prio_s   = cand ? prio_r[k] : best_prio_s;
    end
    irq_cond_s = (best_s != 5'h00) && (best_prio_s > thr_r);
  end

  // One-hot claim and complete strobes towards the gateways
  always_comb begin
    claim_s    = {NUM_SRC{1'b0}};
    complete_s = {NUM_SRC{1'b0}};
    for (int k = 1; k <= NUM_SRC; k++) begin
      claim_s[k]    = claim_go_s && (best_s == 5'(k));
      complete_s[k] = complete_go_s && (DATA_in[4:0] == 5'(k));
    end
  end

  // Read-data mux; anything not decoded reads as zero
  always_comb begin
    rd_data_s = 32'h0;
    if (!rd_win_s) begin
      rd_data_s = 32'h0;
    end else if (rd_ofs_s == IRQC_PEND_OFS) begin
      rd_data_s = pend_vec_s;
    end else if (rd_ofs_s == IRQC_EN_OFS) begin
      rd_data_s = enable_r;
    end else if (rd_ofs_s == IRQC_MODE_OFS) begin
      rd_data_s = mode_r;
    end else if (rd_ofs_s == IRQC_THR_OFS) begin
      rd_data_s = 32'(thr_r);
    end else if (rd_ofs_s == IRQC_CLAIM_OFS) begin
      rd_data_s = irq_cond_s ? {27'h0, best_s} : 32'h0;
    end else if (prio_hit(rd_ofs_s)) begin
      rd_data_s = 32'(prio_r[rd_ofs_s[6:2]]);
    end else begin
      rd_data_s = 32'h0;
    end
  end

  // Register file, read-data register and registered arbitration outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        prio_r[i] <= {PRIO_W{1'b0}};
      end
      enable_r <= 32'h0;
      mode_r   <= 32'h0;
      thr_r    <= {PRIO_W{1'b0}};
      DATA_out <= 32'h0;
      irq_out  <= 1'b0;
      claim_id <= 5'h00;
    end else begin
      if (wr_go_s && prio_hit(wr_ofs_s)) begin
        prio_r[wr_ofs_s[6:2]] <= DATA_in[PRIO_W-1:0];
      end
      if (wr_go_s && (wr_ofs_s == IRQC_EN_OFS)) begin
        enable_r <= DATA_in & SRC_MASK;
      end
      if (wr_go_s && (wr_ofs_s == IRQC_MODE_OFS)) begin
        mode_r <= DATA_in & SRC_MASK;
      end
      if (wr_go_s && (wr_ofs_s == IRQC_THR_OFS)) begin
        thr_r <= DATA_in[PRIO_W-1:0];
      end
      if (read) begin
        DATA_out <= rd_data_s;
      end
      irq_out  <= irq_cond_s;
      claim_id <= best_s;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a source-level behavioural model
// checked every cycle, plus directed register accesses with literal results.
module tb_irq_controller;

  localparam int          N  = 31;
  localparam int          PW = 3;
  localparam int          SS = 2;
  localparam logic [31:0] B       = 32'h8000_0000;
  localparam logic [31:0] A_PEND  = B + 32'h1000;
  localparam logic [31:0] A_EN    = B + 32'h2000;
  localparam logic [31:0] A_MODE  = B + 32'h2004;
  localparam logic [31:0] A_THR   = B + 32'h3000;
  localparam logic [31:0] A_CLAIM = B + 32'h3004;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_src = '0;
  logic         read = 1'b0;
  logic [31:0]  read_address = 32'h0;
  logic [31:0]  DATA_out;
  logic [3:0]   write = 4'h0;
  logic [31:0]  write_address = 32'h0;
  logic [31:0]  DATA_in = 32'h0;
  logic         irq_out;
  logic [4:0]   claim_id;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  irq_controller #(
    .NUM_SRC(N), .PRIO_W(PW), .SYNC_STAGES(SS), .BASE_ADDR(B)
  ) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .read(read), .read_address(read_address), .DATA_out(DATA_out),
    .write(write), .write_address(write_address), .DATA_in(DATA_in),
    .irq_out(irq_out), .claim_id(claim_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_pend[32];
  bit           m_insvc[32];
  bit           m_mode[32];
  bit           m_en[32];
  int           m_prio[32];
  int           m_thr;
  logic [N-1:0] m_dly[SS];
  logic [N-1:0] m_prev;
  logic         exp_irq;
  logic [4:0]   exp_cid;
  logic [31:0]  exp_data;

  function automatic int m_best();
    int b  = 0;
    int bp = 0;
    for (int k = 1; k <= N; k++)
      if (m_pend[k] && m_en[k] && m_prio[k] > bp) begin
        b  = k;
        bp = m_prio[k];
      end
    return b;
  endfunction

  function automatic bit m_cond(input int b);
    return (b != 0) && (m_prio[b] > m_thr);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    logic [31:0] v;
    int b;
    v = 32'h0;
    if (a < B || a > B + 32'h3FFF) return 32'h0;
    off = a - B;
    b = m_best();
    if (off == 32'h1000)      for (int k = 1; k <= N; k++) v[k] = m_pend[k];
    else if (off == 32'h2000) for (int k = 1; k <= N; k++) v[k] = m_en[k];
    else if (off == 32'h2004) for (int k = 1; k <= N; k++) v[k] = m_mode[k];
    else if (off == 32'h3000) v = 32'(m_thr);
    else if (off == 32'h3004) v = m_cond(b) ? 32'(b) : 32'h0;
    else if (off[1:0] == 2'b00 && off >= 32'd4 && off <= 32'(4 * N)) v = 32'(m_prio[off / 4]);
    return v;
  endfunction

  initial forever begin : model
    int b, ck, cj;
    bit cond, set;
    logic [N-1:0] s;
    bit np[32];
    bit ni[32];
    logic [31:0] rd;
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        m_pend[k] = 0; m_insvc[k] = 0; m_mode[k] = 0; m_en[k] = 0; m_prio[k] = 0;
      end
      m_thr = 0;
      for (int i = 0; i < SS; i++) m_dly[i] = '0;
      m_prev = '0;
      exp_irq = 1'b0; exp_cid = 5'h0; exp_data = 32'h0;
    end else begin
      b    = m_best();
      cond = m_cond(b);
      rd   = m_read(read_address);
      ck = (read && read_address == A_CLAIM && cond) ? b : 0;
      cj = (write == 4'hF && write_address == A_CLAIM && DATA_in >= 32'd1 &&
            DATA_in <= 32'(N)) ? int'(DATA_in) : 0;
      s = m_dly[SS-1];
      for (int k = 1; k <= N; k++) begin
        set   = m_mode[k] ? (s[k-1] && !m_prev[k-1])
                          : (s[k-1] && !m_insvc[k] && !m_pend[k]);
        np[k] = (m_pend[k] && k != ck) || set;
        ni[k] = (k == ck) || (m_insvc[k] && k != cj);
      end
      for (int k = 1; k <= N; k++) begin
        m_pend[k]  = np[k];
        m_insvc[k] = ni[k];
      end
      if (write == 4'hF) begin
        if (write_address == A_EN)   for (int k = 1; k <= N; k++) m_en[k] = DATA_in[k];
        if (write_address == A_MODE) for (int k = 1; k <= N; k++) m_mode[k] = DATA_in[k];
        if (write_address == A_THR)  m_thr = int'(DATA_in[PW-1:0]);
        if (write_address[1:0] == 2'b00 && write_address >= B + 32'd4 &&
            write_address <= B + 32'(4 * N))
          m_prio[(write_address - B) / 4] = int'(DATA_in[PW-1:0]);
      end
      exp_irq = cond;
      exp_cid = 5'(b);
      if (read) exp_data = rd;
      m_prev = s;
      for (int i = SS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
      m_dly[0] = irq_src;
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (started && !reset) begin
      check("cyc_irq_out", 32'(irq_out), 32'(exp_irq));
      check("cyc_claim_id", 32'(claim_id), 32'(exp_cid));
      check("cyc_data_out", DATA_out, exp_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    write = be; write_address = a; DATA_in = d;
    @(negedge clk);
    write = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    read = 1'b1; read_address = a;
    @(negedge clk);
    read = 1'b0;
    check(nm, DATA_out, e);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    started = 1'b1;
    check("rst_irq_out", 32'(irq_out), 32'h0);
    check("rst_claim_id", 32'(claim_id), 32'h0);
    check("rst_data_out", DATA_out, 32'h0);
    rd(A_PEND, 32'h0, "rst_pend");
    rd(A_EN, 32'h0, "rst_en");
    rd(A_MODE, 32'h0, "rst_mode");
    rd(A_THR, 32'h0, "rst_thr");
    rd(A_CLAIM, 32'h0, "rst_claim");
    rd(B + 32'd4, 32'h0, "rst_prio1");
    rd(B + 32'd124, 32'h0, "rst_prio31");
    rd(B, 32'h0, "rst_unmapped");
    rd(32'h0000_3000, 32'h0, "rst_outside");

    // edge source 3: latency, claim, complete
    wr(A_MODE, 32'h8); wr(B + 32'd12, 32'd5); wr(A_EN, 32'h8); wr(A_THR, 32'd2);
    irq_src = 31'h4;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) irq_src = '0;
      if (i == 3) check("lat_irq_early", 32'(irq_out), 32'h0);
      if (i == 4) check("lat_irq_on", 32'(irq_out), 32'h1);
    end
    rd(A_CLAIM, 32'd3, "claim3");
    tick(1);
    check("claim3_irq_drop", 32'(irq_out), 32'h0);
    rd(A_PEND, 32'h0, "claim3_pend");
    wr(A_CLAIM, 32'd3);

    // priority ordering and tie-break
    wr(B + 32'd16, 32'd6); wr(B + 32'd28, 32'd6); wr(B + 32'd36, 32'd7);
    wr(A_MODE, 32'h298); wr(A_EN, 32'h298);
    irq_src = 31'h148; tick(1); irq_src = '0; tick(5);
    rd(A_PEND, 32'h290, "prio_pend");
    rd(A_CLAIM, 32'd9, "prio_claim9");
    rd(A_CLAIM, 32'd4, "prio_claim4");
    rd(A_CLAIM, 32'd7, "prio_claim7");
    rd(A_PEND, 32'h0, "prio_pend_empty");
    rd(A_CLAIM, 32'd0, "prio_claim_none");
    wr(A_CLAIM, 32'd9); wr(A_CLAIM, 32'd4); wr(A_CLAIM, 32'd7);

    // level source 5
    wr(B + 32'd20, 32'd4); wr(A_EN, 32'h2B8);
    irq_src = 31'h10; tick(5);
    check("lvl_irq_on", 32'(irq_out), 32'h1);
    rd(A_CLAIM, 32'd5, "lvl_claim5");
    tick(3);
    rd(A_PEND, 32'h0, "lvl_pend_insvc");
    check("lvl_irq_insvc", 32'(irq_out), 32'h0);
    wr(A_CLAIM, 32'd37); wr(A_CLAIM, 32'd0); tick(4);
    rd(A_PEND, 32'h0, "lvl_bad_complete");
    wr(A_CLAIM, 32'd5);
    check("lvl_rearm_c0", 32'(irq_out), 32'h0);
    tick(1); check("lvl_rearm_c1", 32'(irq_out), 32'h0);
    tick(1); check("lvl_rearm_c2", 32'(irq_out), 32'h1);
    rd(A_CLAIM, 32'd5, "lvl_claim5_again");
    irq_src = '0; tick(4);
    wr(A_CLAIM, 32'd5); tick(5);
    check("lvl_no_rearm", 32'(irq_out), 32'h0);
    rd(A_PEND, 32'h0, "lvl_pend_low");

    // threshold on source 6
    wr(A_THR, 32'd6); wr(B + 32'd24, 32'd6); wr(A_EN, 32'h2F8);
    irq_src = 31'h20; tick(5);
    check("thr_irq_blocked", 32'(irq_out), 32'h0);
    check("thr_claim_id", 32'(claim_id), 32'd6);
    rd(A_PEND, 32'h40, "thr_pend");
    rd(A_CLAIM, 32'd0, "thr_claim0");
    rd(A_PEND, 32'h40, "thr_pend_kept");
    wr(A_THR, 32'd5);
    check("thr_irq_c0", 32'(irq_out), 32'h0);
    tick(1); check("thr_irq_c1", 32'(irq_out), 32'h1);
    rd(A_CLAIM, 32'd6, "thr_claim6");
    irq_src = '0; tick(4);
    wr(A_CLAIM, 32'd6); wr(A_THR, 32'd2);

    // edge source 2: re-trigger in service, bogus completes, partial write
    wr(A_MODE, 32'h29C); wr(B + 32'd8, 32'd3); wr(A_EN, 32'h2FC);
    irq_src = 31'h2; tick(1); irq_src = '0; tick(5);
    rd(A_CLAIM, 32'd2, "edge_claim2");
    tick(2);
    irq_src = 31'h2; tick(1); irq_src = '0; tick(5);
    rd(A_PEND, 32'h4, "edge_repend");
    check("edge_irq_insvc", 32'(irq_out), 32'h1);
    wr(A_CLAIM, 32'd0); wr(A_CLAIM, 32'd40); wr(A_CLAIM, 32'd3);
    rd(A_PEND, 32'h4, "edge_bad_complete");
    wr(A_EN, 32'h0, 4'b0011);
    rd(A_EN, 32'h2FC, "partial_write");
    wr(A_CLAIM, 32'd2);
    rd(A_CLAIM, 32'd2, "edge_claim2_again");
    wr(A_CLAIM, 32'd2);
    rd(A_PEND, 32'h0, "edge_pend_clear");

    // field widths and decode boundaries
    wr(B + 32'd4, 32'hFFFF_FFFF);
    rd(B + 32'd4, 32'd7, "prio_width");
    wr(A_MODE, 32'hFFFF_FFFF);
    rd(A_MODE, 32'hFFFF_FFFE, "mode_bit0");
    wr(A_MODE, 32'h29C);
    wr(32'h0000_3000, 32'd7); wr(B + 32'h3008, 32'd7);
    rd(A_THR, 32'd2, "thr_decode");

    // reset in the middle of an active request
    irq_src = 31'h20; tick(5);
    check("mid_irq_on", 32'(irq_out), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_irq", 32'(irq_out), 32'h0);
    check("mid_rst_cid", 32'(claim_id), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(A_PEND, 32'h0, "mid_pend");
    rd(A_EN, 32'h0, "mid_en");
    irq_src = '0; tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
